intr_ctrl: RTL

Parametrised vectored interrupt controller for the single-cycle CPU datapath. It replaces the fixed two-source, hard-wired-vector interrupt path (OR'd push, fixed interrupt registers) with N edge-triggered channels, per-channel mask, global enable, fixed priority and optional nesting. It sits beside the program counter: it drives the PC-select/vector path and the stack push, and receives acknowledge and return-from-interrupt strobes from the control unit.

---
 rtl/intr_pkg.sv | 10 +
 rtl/prio_enc.sv | 14 +
 rtl/intr_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared FSM state type, priority helper and default vector layout for intr_ctrl.
package intr_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [9:0] DEF_VEC_BASE = 10'h3C0;
  localparam int DEF_VEC_STRIDE = 4;
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest_set = 4'(i);
  endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index priority encoder with valid flag (index 0 wins).
module prio_enc
  import intr_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  assign valid = |req;
  assign idx = W'(lowest_set(16'(req)));
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: vectored interrupt controller with edge-triggered channels, mask,
// global enable, fixed priority and optional nesting.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] VEC_BASE = PC_WIDTH'(DEF_VEC_BASE),
  parameter int VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int NESTING = 0,
  localparam int IW = N_IRQ > 1 ? $clog2(N_IRQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic                mask_we,
  input  logic [N_IRQ-1:0]    mask_wd,
  input  logic                ie_set,
  input  logic                ie_clr,
  input  logic                irq_ack,
  input  logic                reti,
  output logic                irq_req,
  output logic [PC_WIDTH-1:0] irq_vec,
  output logic [IW-1:0]       irq_id,
  output logic [N_IRQ-1:0]    pending,
  output logic [N_IRQ-1:0]    in_service,
  output logic                ie
);
  state_t state;
  logic [N_IRQ-1:0] irq_q, mask, rise, elig, ack_oh, reti_oh;
  logic [IW-1:0] cand_idx, isr_idx;
  logic cand_v, isr_v, allowed, ack_fire, reti_fire, ie_next;
  assign rise = irq_in & ~irq_q;
  assign elig = pending & mask;
  prio_enc #(.N(N_IRQ), .W(IW)) u_cand (.req(elig), .valid(cand_v), .idx(cand_idx));
  prio_enc #(.N(N_IRQ), .W(IW)) u_isr (.req(in_service), .valid(isr_v), .idx(isr_idx));
  assign allowed = ie && cand_v && (!isr_v || (NESTING != 0 && cand_idx < isr_idx));
  assign ack_fire = state == REQ && irq_ack;
  assign reti_fire = reti && isr_v;
  assign ack_oh = ack_fire ? N_IRQ'(1) << irq_id : '0;
  assign reti_oh = reti_fire ? N_IRQ'(1) << isr_idx : '0;
  // clears dominate sets: DI over EI, and an ack auto-disable over EI
  assign ie_next = !(ie_clr || (ack_fire && NESTING == 0)) &&
                   (ie || ie_set || (reti_fire && NESTING == 0));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
      mask <= '0;
      pending <= '0;
      in_service <= '0;
      ie <= 1'b0;
    end else begin
      irq_q <= irq_in;
      if (mask_we) mask <= mask_wd;
      pending <= (pending & ~ack_oh) | rise;
      in_service <= (in_service & ~reti_oh) | ack_oh;
      ie <= ie_next;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
      irq_id <= '0;
    end else if (state == IDLE) begin
      if (allowed) begin
        state <= REQ;
        irq_req <= 1'b1;
        irq_id <= cand_idx;
        irq_vec <= PC_WIDTH'(int'(VEC_BASE) + int'(cand_idx) * VEC_STRIDE);
      end
    end else if (irq_ack) begin
      state <= IDLE;
      irq_req <= 1'b0;
    end
  end
endmodule
